// File: rtl/lsu_mem_initiator.sv
`default_nettype none
// ============================================================================
// Module   : lsu_mem_initiator
// Brief    : Memory-stage load/store initiator driving a valid/ready word bus
//            with byte strobes, load extension, misalign and timeout flags.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_mem_initiator #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic        op_is_store,
    input  logic [2:0]  op_funct3,
    input  logic [31:0] op_addr,
    input  logic [31:0] op_wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] load_data,
    output logic        misaligned,
    output logic        bus_err,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_req_we,
    output logic [31:0] mem_req_addr,
    output logic [3:0]  mem_req_wstrb,
    output logic [31:0] mem_req_wdata,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_rdata
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_REQ      = 2'd1,
        S_WAIT_RSP = 2'd2,
        S_DONE     = 2'd3
    } state_t;

    localparam logic [15:0] c_TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_cnt;
    logic        r_is_store;
    logic [2:0]  r_funct3;
    logic [1:0]  r_lane;
    logic [31:0] r_addr;
    logic [3:0]  r_wstrb;
    logic [31:0] r_wdata;
    logic [31:0] r_load_data;
    logic        r_misaligned;
    logic        r_bus_err;

    logic        w_bad;
    logic [3:0]  w_st_strb;
    logic [31:0] w_st_data;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ext;
    logic        w_hs;
    logic        w_timeout;
    logic        w_expire;

    // Reject misaligned accesses and illegal encodings (BU/HU are load-only)
    always_comb begin
        w_bad = 1'b0;
        case (op_funct3)
            3'b000:  w_bad = 1'b0;
            3'b001:  w_bad = op_addr[0];
            3'b010:  w_bad = |op_addr[1:0];
            3'b100:  w_bad = op_is_store;
            3'b101:  w_bad = op_is_store | op_addr[0];
            default: w_bad = 1'b1;
        endcase
    end

    always_comb begin
        w_st_strb = 4'b1111;
        w_st_data = op_wdata;
        case (op_funct3[1:0])
            2'b00: begin
                w_st_strb = 4'b0001 << op_addr[1:0];
                w_st_data = {4{op_wdata[7:0]}};
            end
            2'b01: begin
                w_st_strb = op_addr[1] ? 4'b1100 : 4'b0011;
                w_st_data = {2{op_wdata[15:0]}};
            end
            default: begin
                w_st_strb = 4'b1111;
                w_st_data = op_wdata;
            end
        endcase
        if (!op_is_store) begin
            w_st_strb = 4'b0000;
            w_st_data = 32'd0;
        end
    end

    always_comb begin
        w_byte = mem_rsp_rdata[7:0];
        case (r_lane)
            2'd0:    w_byte = mem_rsp_rdata[7:0];
            2'd1:    w_byte = mem_rsp_rdata[15:8];
            2'd2:    w_byte = mem_rsp_rdata[23:16];
            default: w_byte = mem_rsp_rdata[31:24];
        endcase
        w_half = r_lane[1] ? mem_rsp_rdata[31:16] : mem_rsp_rdata[15:0];
        w_ext  = mem_rsp_rdata;
        case (r_funct3)
            3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_ext = {{16{w_half[15]}}, w_half};
            3'b100:  w_ext = {24'd0, w_byte};
            3'b101:  w_ext = {16'd0, w_half};
            default: w_ext = mem_rsp_rdata;
        endcase
    end

    assign w_hs      = (r_state == S_REQ) && mem_req_ready;
    assign w_timeout = (r_cnt == c_TIMEOUT_LAST);
    // Completion in the expiry cycle takes priority over the timeout
    assign w_expire  = w_timeout &&
                       (((r_state == S_REQ) && !mem_req_ready) ||
                        ((r_state == S_WAIT_RSP) && !mem_rsp_valid));

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (op_valid) begin
                    w_next = w_bad ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                if (w_hs) begin
                    w_next = r_is_store ? S_DONE : S_WAIT_RSP;
                end else if (w_expire) begin
                    w_next = S_DONE;
                end
            end
            S_WAIT_RSP: begin
                if (mem_rsp_valid || w_expire) begin
                    w_next = S_DONE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= 16'd0;
            r_is_store   <= 1'b0;
            r_funct3     <= 3'd0;
            r_lane       <= 2'd0;
            r_addr       <= 32'd0;
            r_wstrb      <= 4'd0;
            r_wdata      <= 32'd0;
            r_load_data  <= 32'd0;
            r_misaligned <= 1'b0;
            r_bus_err    <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_misaligned <= (r_state == S_IDLE) && op_valid && w_bad;
            r_bus_err    <= w_expire;
            if (r_state == S_IDLE) begin
                r_cnt <= 16'd0;
            end else if ((r_state == S_REQ) || (r_state == S_WAIT_RSP)) begin
                r_cnt <= r_cnt + 16'd1;
            end
            if ((r_state == S_IDLE) && op_valid) begin
                r_is_store <= op_is_store;
                r_funct3   <= op_funct3;
                r_lane     <= op_addr[1:0];
                r_addr     <= {op_addr[31:2], 2'b00};
                r_wstrb    <= w_st_strb;
                r_wdata    <= w_st_data;
            end
            if ((r_state == S_WAIT_RSP) && mem_rsp_valid) begin
                r_load_data <= w_ext;
            end else if (w_expire) begin
                r_load_data <= 32'd0;
            end
        end
    end

    assign stall         = op_valid && (r_state != S_DONE);
    assign done          = (r_state == S_DONE);
    assign load_data     = r_load_data;
    assign misaligned    = r_misaligned;
    assign bus_err       = r_bus_err;
    assign mem_req_valid = (r_state == S_REQ);
    assign mem_req_we    = r_is_store;
    assign mem_req_addr  = r_addr;
    assign mem_req_wstrb = r_wstrb;
    assign mem_req_wdata = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_initiator.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_mem_initiator
// Brief    : Directed self-checking bench for lsu_mem_initiator.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_mem_initiator;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid, op_is_store;
    logic [2:0]  op_funct3;
    logic [31:0] op_addr, op_wdata;
    logic        ready, rsp_valid;
    logic [31:0] rdata;

    logic        stall, done, mis, berr, rv, we;
    logic [31:0] ld, addr, wdata;
    logic [3:0]  wstrb;

    logic        t_stall, t_done, t_mis, t_berr, t_rv, t_we;
    logic [31:0] t_ld, t_addr, t_wdata;
    logic [3:0]  t_wstrb;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    lsu_mem_initiator dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_is_store(op_is_store),
        .op_funct3(op_funct3), .op_addr(op_addr), .op_wdata(op_wdata),
        .stall(stall), .done(done), .load_data(ld), .misaligned(mis),
        .bus_err(berr), .mem_req_valid(rv), .mem_req_ready(ready),
        .mem_req_we(we), .mem_req_addr(addr), .mem_req_wstrb(wstrb),
        .mem_req_wdata(wdata), .mem_rsp_valid(rsp_valid), .mem_rsp_rdata(rdata)
    );

    lsu_mem_initiator #(.TIMEOUT_CYCLES(8)) dut_t (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_is_store(op_is_store),
        .op_funct3(op_funct3), .op_addr(op_addr), .op_wdata(op_wdata),
        .stall(t_stall), .done(t_done), .load_data(t_ld), .misaligned(t_mis),
        .bus_err(t_berr), .mem_req_valid(t_rv), .mem_req_ready(ready),
        .mem_req_we(t_we), .mem_req_addr(t_addr), .mem_req_wstrb(t_wstrb),
        .mem_req_wdata(t_wdata), .mem_rsp_valid(rsp_valid), .mem_rsp_rdata(rdata)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; op_valid = 1'b0; rsp_valid = 1'b0; ready = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd, input logic [3:0] e_strb,
                            input logic [31:0] e_data);
        op_valid = 1'b1; op_is_store = 1'b1; op_funct3 = f3; op_addr = a;
        op_wdata = wd; ready = 1'b1;
        tick();
        chk({tag, "_rv"}, rv, 1);
        chk({tag, "_addr"}, addr, {a[31:2], 2'b00});
        chk({tag, "_strb"}, wstrb, e_strb);
        chk({tag, "_wdata"}, wdata, e_data);
        tick();
        chk({tag, "_done"}, done, 1);
        op_valid = 1'b0;
        tick();
    endtask

    task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] rd, input int dly, input logic [31:0] e_ld);
        op_valid = 1'b1; op_is_store = 1'b0; op_funct3 = f3; op_addr = a;
        ready = 1'b1;
        tick();
        chk({tag, "_rv"}, rv, 1);
        chk({tag, "_we"}, we, 0);
        chk({tag, "_strb"}, wstrb, 0);
        chk({tag, "_addr"}, addr, {a[31:2], 2'b00});
        tick();
        chk({tag, "_wait_stall"}, stall, 1);
        repeat (dly - 1) tick();
        rsp_valid = 1'b1; rdata = rd;
        tick();
        chk({tag, "_done"}, done, 1);
        chk({tag, "_ld"}, ld, e_ld);
        rsp_valid = 1'b0; op_valid = 1'b0; rdata = 32'h0BAD_0BAD;
        tick();
        chk({tag, "_done_off"}, done, 0);
        chk({tag, "_ld_hold"}, ld, e_ld);
    endtask

    task automatic do_misal(input string tag, input logic st, input logic [2:0] f3,
                            input logic [31:0] a);
        op_valid = 1'b1; op_is_store = st; op_funct3 = f3; op_addr = a;
        op_wdata = 32'h1234_5678; ready = 1'b1;
        #1;
        chk({tag, "_stall"}, stall, 1);
        tick();
        chk({tag, "_done"}, done, 1);
        chk({tag, "_mis"}, mis, 1);
        chk({tag, "_rv"}, rv, 0);
        op_valid = 1'b0;
        tick();
        chk({tag, "_mis_off"}, mis, 0);
        chk({tag, "_rv_off"}, rv, 0);
    endtask

    initial begin
        rst = 1'b1; op_valid = 1'b0; op_is_store = 1'b0; op_funct3 = 3'd0;
        op_addr = 32'd0; op_wdata = 32'd0; ready = 1'b0; rsp_valid = 1'b0;
        rdata = 32'd0;
        repeat (2) tick();
        rst = 1'b0;

        // Reset state
        chk("rst_stall", stall, 0);
        chk("rst_done", done, 0);
        chk("rst_rv", rv, 0);
        chk("rst_ld", ld, 0);
        chk("rst_wstrb", wstrb, 0);
        chk("rst_flags", {30'd0, mis, berr}, 0);

        // SB to lane 3 with immediate ready
        op_valid = 1'b1; op_is_store = 1'b1; op_funct3 = 3'b000;
        op_addr = 32'h0000_0103; op_wdata = 32'h0000_00A5; ready = 1'b1;
        #1;
        chk("sb_stall_c0", stall, 1);
        chk("sb_rv_c0", rv, 0);
        tick();
        chk("sb_stall_c1", stall, 1);
        chk("sb_rv", rv, 1);
        chk("sb_we", we, 1);
        chk("sb_addr", addr, 32'h0000_0100);
        chk("sb_strb", wstrb, 4'b1000);
        chk("sb_wdata", wdata, 32'hA5A5_A5A5);
        chk("sb_done_c1", done, 0);
        tick();
        chk("sb_done", done, 1);
        chk("sb_stall_c2", stall, 0);
        chk("sb_rv_c2", rv, 0);
        chk("sb_mis", mis, 0);
        op_valid = 1'b0;
        tick();
        chk("sb_done_off", done, 0);

        do_store("sh2", 3'b001, 32'h0000_0102, 32'h1234_BEEF, 4'b1100, 32'hBEEF_BEEF);
        do_store("sh0", 3'b001, 32'h0000_0100, 32'h1234_BEEF, 4'b0011, 32'hBEEF_BEEF);
        do_store("sb0", 3'b000, 32'h0000_0200, 32'h0000_0077, 4'b0001, 32'h7777_7777);

        // Loads with extension
        do_load("lb",  3'b000, 32'h0000_0201, 32'h1234_80FF, 3, 32'hFFFF_FF80);
        do_load("lbu", 3'b100, 32'h0000_0201, 32'h1234_80FF, 3, 32'h0000_0080);
        do_load("lhu", 3'b101, 32'h0000_0202, 32'h1234_80FF, 3, 32'h0000_1234);
        do_load("lh",  3'b001, 32'h0000_0200, 32'h1234_80FF, 1, 32'hFFFF_80FF);
        do_load("lb3", 3'b000, 32'h0000_0203, 32'h7F34_80FF, 2, 32'h0000_007F);
        do_load("lw",  3'b010, 32'h0000_0204, 32'h1234_80FF, 1, 32'h1234_80FF);

        // Misaligned / illegal
        do_misal("lw6",  1'b0, 3'b010, 32'h0000_0006);
        do_misal("sh5",  1'b1, 3'b001, 32'h0000_0005);
        do_misal("sbu",  1'b1, 3'b100, 32'h0000_0000);
        do_misal("f011", 1'b0, 3'b011, 32'h0000_0000);

        // SW with ready withheld for 10 cycles
        do_reset();
        op_valid = 1'b1; op_is_store = 1'b1; op_funct3 = 3'b010;
        op_addr = 32'h0000_0040; op_wdata = 32'hDEAD_BEEF; ready = 1'b0;
        tick();
        for (int i = 0; i < 10; i++) begin
            chk("sw_hold", {rv, wstrb, addr[26:0]}, {1'b1, 4'b1111, 27'h40});
            chk("sw_hold_wdata", wdata, 32'hDEAD_BEEF);
            chk("sw_hold_done", done, 0);
            tick();
        end
        ready = 1'b1;
        #1;
        chk("sw_rv_hs", rv, 1);
        tick();
        chk("sw_done", done, 1);
        chk("sw_berr", berr, 0);
        op_valid = 1'b0;
        tick();

        // Timeout with TIMEOUT_CYCLES=8
        do_reset();
        do_load("pre", 3'b010, 32'h0000_0008, 32'h1111_2222, 3, 32'h1111_2222);
        chk("pre_t_ld", t_ld, 32'h1111_2222);
        op_valid = 1'b1; op_is_store = 1'b0; op_funct3 = 3'b010;
        op_addr = 32'h0000_0010; ready = 1'b1;
        tick();
        chk("to_rv", t_rv, 1);
        for (int i = 1; i < 8; i++) begin
            tick();
            chk("to_early_done", {t_done, t_berr}, 2'b00);
        end
        tick();
        chk("to_done", t_done, 1);
        chk("to_berr", t_berr, 1);
        chk("to_ld", t_ld, 0);
        chk("to_rv_off", t_rv, 0);
        op_valid = 1'b0;
        tick();
        chk("to_berr_off", {t_done, t_berr}, 2'b00);
        op_valid = 1'b1; op_addr = 32'h0000_0020;
        tick();
        chk("to_next_rv", t_rv, 1);
        tick();
        rsp_valid = 1'b1; rdata = 32'hCAFE_F00D;
        tick();
        chk("to_next_done", t_done, 1);
        chk("to_next_berr", t_berr, 0);
        chk("to_next_ld", t_ld, 32'hCAFE_F00D);
        rsp_valid = 1'b0; op_valid = 1'b0;
        tick();

        // Handshake in the expiry cycle wins
        do_reset();
        op_valid = 1'b1; op_is_store = 1'b1; op_funct3 = 3'b010;
        op_addr = 32'h0000_0000; op_wdata = 32'h1; ready = 1'b0;
        tick();
        repeat (7) tick();
        chk("hs_to_rv", t_rv, 1);
        ready = 1'b1;
        tick();
        chk("hs_to_done", t_done, 1);
        chk("hs_to_berr", t_berr, 0);
        op_valid = 1'b0;
        tick();

        // Reset while in WAIT_RSP, late response ignored
        do_reset();
        op_valid = 1'b1; op_is_store = 1'b0; op_funct3 = 3'b010;
        op_addr = 32'h0000_0030; ready = 1'b1;
        tick();
        tick();
        chk("rw_stall_wait", stall, 1);
        rst = 1'b1; op_valid = 1'b0;
        tick();
        rst = 1'b0; rsp_valid = 1'b1; rdata = 32'h5555_5555;
        #1;
        chk("rw_rv", rv, 0);
        chk("rw_done", done, 0);
        tick();
        rsp_valid = 1'b0;
        chk("rw_done_after", done, 0);
        chk("rw_ld", ld, 0);
        chk("rw_rv_after", rv, 0);
        tick();
        chk("rw_done_late", done, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lsu_mem_initiator.md
Name: lsu_mem_initiator

Overview:
- Memory-stage load/store initiator: the requesting end of the data-memory interface.
- Converts a pipeline memory op (RV32I funct3 encoding) into a valid/ready word request with byte strobes.
- Waits for load data and returns sign- or zero-extended writeback data.
- Holds the pipeline via `stall`; flags misaligned accesses and response timeouts.

Parameters:
- TIMEOUT_CYCLES, 64: cycles allowed from request issue to completion before `bus_err`. Legal range 2..65535.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- op_valid  in  1  memory op present in memory stage; held stable while stall=1
- op_is_store  in  1  1 = store, 0 = load
- op_funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU; BU/HU are load-only
- op_addr  in  32  byte address
- op_wdata  in  32  store data, low bits significant
- stall  out  1  hold upstream pipeline
- done  out  1  one-cycle completion pulse
- load_data  out  32  extended load result; valid when done=1 for a load
- misaligned  out  1  one-cycle pulse; access rejected, no request issued
- bus_err  out  1  one-cycle pulse; timeout expired
- mem_req_valid  out  1  request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_we  out  1  1 = write
- mem_req_addr  out  32  {op_addr[31:2], 2'b00}
- mem_req_wstrb  out  4  byte enables; 0000 for loads
- mem_req_wdata  out  32  lane-replicated store data
- mem_rsp_valid  in  1  load data valid; one cycle per load request
- mem_rsp_rdata  in  32  load word

Behaviour:
- FSM states: IDLE, REQ, WAIT_RSP, DONE.
- Reset (synchronous): state=IDLE, timeout counter=0. All outputs 0: stall, done, misaligned, bus_err, mem_req_*, load_data.
- stall is combinational: op_valid & (state!=DONE). It is therefore 1 in the IDLE cycle an op arrives.

IDLE, op_valid=1:
- Op, address and data are captured into registers.
- Misaligned if H/HU with addr[0]=1, W with addr[1:0]!=00, or an illegal funct3 (011, 11x, or store with BU/HU). In that case: go to DONE with misaligned=1 asserted together with done; no request is issued.
- Otherwise go to REQ.

REQ:
- mem_req_valid=1; request fields are driven from captured registers and held stable until handshake.
- On valid&ready: a store goes to DONE; a load goes to WAIT_RSP.

WAIT_RSP:
- On mem_rsp_valid: latch extended data into load_data, go to DONE.
- mem_rsp_valid arriving in any other state is ignored.

DONE:
- done=1 for exactly one cycle, then IDLE.
- op_valid is ignored in DONE (the pipeline advances); minimum op-to-op spacing is one idle cycle.

Timeout:
- Counter clears on entry to REQ and increments each cycle in REQ or WAIT_RSP.
- On reaching TIMEOUT_CYCLES-1 without completion: go to DONE with bus_err=1 and done=1, load_data=0, mem_req_valid dropped.

Store lanes (lane = addr[1:0]):
- B: wstrb = 0001<<lane, wdata = {4{b}}.
- H: wstrb = 0011 (lane 0) or 1100 (lane 2), wdata = {2{h}}.
- W: wstrb = 1111, wdata as-is.

Load extraction:
- Select rdata byte `lane`, or halfword lane[1].
- B/H sign-extend; BU/HU zero-extend; W returns rdata as-is.
- load_data holds its value until the next load completes.

Reset mid-operation:
- Any state returns to IDLE next cycle; mem_req_valid=0 that cycle.
- A late mem_rsp_valid after reset is ignored.

Simultaneous events:
- Handshake and timeout expiry in the same cycle: the handshake wins.

Test Plan:
1. SB addr=0x0000_0103, wdata=0x0000_00A5, ready=1 immediately -> one request with we=1, addr=0x100, wstrb=1000, wdata=0xA5A5_A5A5; done pulses 2 cycles after op_valid; stall high exactly those 2 cycles.
2. LB addr=0x0000_0201, rdata=0x1234_80FF, rsp 3 cycles after handshake -> load_data=0xFFFF_FF80 on done. LBU with the same rdata -> 0x0000_0080. LHU at 0x202 -> 0x0000_1234.
3. LW addr=0x0000_0006 -> misaligned=1 and done=1 in the same cycle, mem_req_valid never asserts. SH at 0x5 -> same. funct3=100 with store -> misaligned.
4. SW with ready held 0 for 10 cycles, then 1 -> mem_req_addr/wstrb/wdata stable all 10 cycles; done one cycle after the handshake.
5. TIMEOUT_CYCLES=8, LW, ready=1 but mem_rsp_valid never asserts -> bus_err=1 and done=1 at cycle 8 after REQ entry, load_data=0; a following LW completes normally.
6. rst asserted while in WAIT_RSP, then rsp_valid asserted the next cycle -> state IDLE, no done, load_data=0, mem_req_valid=0.
